// File: rtl/sa_aw_channel_if.sv
// AW-stage bundle: dispatcher requests, slave-side AW register and the
// ordering strobes toward the write-response and write-data stages.
interface sa_aw_channel_if #(
  parameter int unsigned MST_AMT           = 3,
  parameter int unsigned MST_ID_W          = $clog2(MST_AMT),
  parameter int unsigned TRANS_MST_ID_W    = 5,
  parameter int unsigned TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned TRANS_DATA_LEN_W  = 8,
  parameter int unsigned TRANS_DATA_SIZE_W = 3
) ();

  logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_AWID_i;
  logic [ADDR_WIDTH*MST_AMT-1:0]        dsp_AWADDR_i;
  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]  dsp_AWLEN_i;
  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0] dsp_AWSIZE_i;
  logic [MST_AMT-1:0]                   dsp_AW_crossing_flag_i;
  logic [MST_AMT-1:0]                   dsp_AWVALID_i;
  logic [MST_AMT-1:0]                   dsp_AWREADY_o;

  logic [TRANS_SLV_ID_W-1:0]            m_AWID_o;
  logic [ADDR_WIDTH-1:0]                m_AWADDR_o;
  logic [TRANS_DATA_LEN_W-1:0]          m_AWLEN_o;
  logic [TRANS_DATA_SIZE_W-1:0]         m_AWSIZE_o;
  logic                                 m_AWVALID_o;
  logic                                 m_AWREADY_i;

  logic [TRANS_SLV_ID_W-1:0]            AW_AxID_o;
  logic                                 AW_crossing_flag_o;
  logic                                 AW_shift_en_o;
  logic                                 AW_stall_i;

  logic [MST_ID_W-1:0]                  W_mst_id_o;
  logic [TRANS_DATA_LEN_W-1:0]          W_AWLEN_o;
  logic                                 W_push_o;
  logic                                 W_stall_i;

  // The arbiter is the slave of this bundle.
  modport slave (
    input  dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWSIZE_i,
    input  dsp_AW_crossing_flag_i, dsp_AWVALID_i,
    output dsp_AWREADY_o,
    output m_AWID_o, m_AWADDR_o, m_AWLEN_o, m_AWSIZE_o, m_AWVALID_o,
    input  m_AWREADY_i,
    output AW_AxID_o, AW_crossing_flag_o, AW_shift_en_o,
    input  AW_stall_i,
    output W_mst_id_o, W_AWLEN_o, W_push_o,
    input  W_stall_i
  );

  modport master (
    output dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWSIZE_i,
    output dsp_AW_crossing_flag_i, dsp_AWVALID_i,
    input  dsp_AWREADY_o,
    input  m_AWID_o, m_AWADDR_o, m_AWLEN_o, m_AWSIZE_o, m_AWVALID_o,
    output m_AWREADY_i,
    input  AW_AxID_o, AW_crossing_flag_o, AW_shift_en_o,
    output AW_stall_i,
    input  W_mst_id_o, W_AWLEN_o, W_push_o,
    output W_stall_i
  );

endinterface

// File: rtl/sa_aw_channel.sv
// Slave-arbiter write-address stage: round-robin AW arbitration into a one-entry output register.
// Define SA_AW_FIXED_PRIORITY_EN for lowest-index-wins arbitration without a grant pointer.
module sa_aw_channel #(
  parameter int unsigned MST_AMT           = 3,
  parameter int unsigned MST_ID_W          = $clog2(MST_AMT),
  parameter int unsigned TRANS_MST_ID_W    = 5,
  parameter int unsigned TRANS_SLV_ID_W    = TRANS_MST_ID_W + MST_ID_W,
  parameter int unsigned ADDR_WIDTH        = 32,
  parameter int unsigned TRANS_DATA_LEN_W  = 8,
  parameter int unsigned TRANS_DATA_SIZE_W = 3
) (
  input  logic             ACLK_i,
  input  logic             ARESET_i,
  sa_aw_channel_if.slave   bus
);

  typedef enum logic [0:0] {StEmpty, StHeld} state_e;

  state_e                         state_q;
  logic [TRANS_SLV_ID_W-1:0]      m_awid_q;
  logic [ADDR_WIDTH-1:0]          m_awaddr_q;
  logic [TRANS_DATA_LEN_W-1:0]    m_awlen_q;
  logic [TRANS_DATA_SIZE_W-1:0]   m_awsize_q;

  logic                           slot_free;
  logic                           arb_en;
  logic                           grant_vld;
  logic [MST_ID_W-1:0]            grant_idx;

  logic [TRANS_MST_ID_W-1:0]      sel_id;
  logic [ADDR_WIDTH-1:0]          sel_addr;
  logic [TRANS_DATA_LEN_W-1:0]    sel_len;
  logic [TRANS_DATA_SIZE_W-1:0]   sel_size;
  logic                           sel_cross;
  logic [MST_AMT-1:0]             dsp_ready;

  assign slot_free = (state_q == StEmpty) | bus.m_AWREADY_i;
  // Reset gates the strobes combinationally so nothing is granted while it is held.
  assign arb_en    = slot_free & ~bus.AW_stall_i & ~bus.W_stall_i & grant_vld & ~ARESET_i;

`ifdef SA_AW_FIXED_PRIORITY_EN
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < MST_AMT; k++) begin
      if (!grant_vld && bus.dsp_AWVALID_i[k]) begin
        grant_vld = 1'b1;
        grant_idx = MST_ID_W'(k);
      end
    end
  end
`else
  logic [MST_ID_W-1:0] last_grant_q;

  // base <= MST_AMT-1 and off <= MST_AMT, so one subtraction wraps correctly.
  function automatic int unsigned rr_idx(input int unsigned base, input int unsigned off);
    int unsigned s;
    s = base + off;
    return (s >= MST_AMT) ? s - MST_AMT : s;
  endfunction

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= MST_AMT; k++) begin
      if (!grant_vld && bus.dsp_AWVALID_i[rr_idx(32'(last_grant_q), k)]) begin
        grant_vld = 1'b1;
        grant_idx = MST_ID_W'(rr_idx(32'(last_grant_q), k));
      end
    end
  end
`endif

  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_cross = 1'b0;
    for (int unsigned k = 0; k < MST_AMT; k++) begin
      if (grant_idx == MST_ID_W'(k)) begin
        sel_id    = bus.dsp_AWID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        sel_addr  = bus.dsp_AWADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = bus.dsp_AWLEN_i[k*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        sel_size  = bus.dsp_AWSIZE_i[k*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
        sel_cross = bus.dsp_AW_crossing_flag_i[k];
      end
    end
  end

  always_comb begin
    dsp_ready = '0;
    if (arb_en) begin
      dsp_ready[grant_idx] = 1'b1;
    end
  end

  assign bus.dsp_AWREADY_o      = dsp_ready;
  assign bus.AW_shift_en_o      = arb_en;
  assign bus.AW_AxID_o          = arb_en ? {grant_idx, sel_id} : '0;
  assign bus.AW_crossing_flag_o = arb_en & sel_cross;
  assign bus.W_push_o           = arb_en;
  assign bus.W_mst_id_o         = arb_en ? grant_idx : '0;
  assign bus.W_AWLEN_o          = arb_en ? sel_len : '0;

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      state_q      <= StEmpty;
      m_awid_q     <= '0;
      m_awaddr_q   <= '0;
      m_awlen_q    <= '0;
      m_awsize_q   <= '0;
`ifndef SA_AW_FIXED_PRIORITY_EN
      last_grant_q <= MST_ID_W'(MST_AMT - 1);
`endif
    end else begin
      unique case (state_q)
        StEmpty: if (arb_en) state_q <= StHeld;
        StHeld:  if (bus.m_AWREADY_i && !arb_en) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
      if (arb_en) begin
        m_awid_q     <= {grant_idx, sel_id};
        m_awaddr_q   <= sel_addr;
        m_awlen_q    <= sel_len;
        m_awsize_q   <= sel_size;
`ifndef SA_AW_FIXED_PRIORITY_EN
        last_grant_q <= grant_idx;
`endif
      end
    end
  end

  assign bus.m_AWVALID_o = (state_q == StHeld);
  assign bus.m_AWID_o    = m_awid_q;
  assign bus.m_AWADDR_o  = m_awaddr_q;
  assign bus.m_AWLEN_o   = m_awlen_q;
  assign bus.m_AWSIZE_o  = m_awsize_q;

endmodule

// File: tb/tb_sa_aw_channel.sv
// Randomised scoreboard bench for sa_aw_channel; expected slave-side transactions are queued
// by a reference arbiter model and popped by an independent output monitor.
module tb_sa_aw_channel;

  localparam int NM = 3;
  localparam int IW = 5;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int SW = 3;

  typedef struct packed {
    logic [IW+1:0] id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [SW-1:0] size;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sa_aw_channel_if bus ();

  sa_aw_channel dut (
    .ACLK_i   (clk),
    .ARESET_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t expq[$];

  // Dispatcher model: each master holds one request until it is accepted.
  logic          pend_v [NM];
  logic [IW-1:0] pend_id[NM];
  logic [AW-1:0] pend_ad[NM];
  logic [LW-1:0] pend_ln[NM];
  logic [SW-1:0] pend_sz[NM];
  logic          pend_x [NM];

  int   ptr = NM - 1;
  logic model_held = 1'b0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic new_req(input int m);
    pend_v[m]  = 1'b1;
    pend_id[m] = IW'($urandom);
    pend_ad[m] = $urandom;
    pend_ln[m] = LW'($urandom);
    pend_sz[m] = SW'($urandom);
    pend_x[m]  = 1'($urandom);
  endtask

  task automatic drive_bus();
    for (int m = 0; m < NM; m++) begin
      bus.dsp_AWVALID_i[m]          = pend_v[m];
      bus.dsp_AWID_i[m*IW +: IW]    = pend_id[m];
      bus.dsp_AWADDR_i[m*AW +: AW]  = pend_ad[m];
      bus.dsp_AWLEN_i[m*LW +: LW]   = pend_ln[m];
      bus.dsp_AWSIZE_i[m*SW +: SW]  = pend_sz[m];
      bus.dsp_AW_crossing_flag_i[m] = pend_x[m];
    end
  endtask

  // Reference: who should win this cycle, given the rules and the model's own pointer.
  task automatic model_check();
    int   g;
    logic slot;
    check("m_awvalid", bus.m_AWVALID_o, model_held);
    slot = !model_held || bus.m_AWREADY_i;
    g = -1;
    if (slot && !bus.AW_stall_i && !bus.W_stall_i) begin
      for (int k = 1; k <= NM; k++) begin
`ifdef SA_AW_FIXED_PRIORITY_EN
        int c = k - 1;
`else
        int c = (ptr + k) % NM;
`endif
        if (g < 0 && pend_v[c]) g = c;
      end
    end
    check("awready", bus.dsp_AWREADY_o, (g >= 0) ? (64'd1 << g) : 64'd0);
    check("shift_en", bus.AW_shift_en_o, g >= 0);
    check("w_push", bus.W_push_o, g >= 0);
    if (g >= 0) begin
      exp_t e;
      e.id   = (IW+2)'((g << IW) + pend_id[g]);
      e.addr = pend_ad[g];
      e.len  = pend_ln[g];
      e.size = pend_sz[g];
      check("aw_axid", bus.AW_AxID_o, e.id);
      check("aw_cross", bus.AW_crossing_flag_o, pend_x[g]);
      check("w_mst_id", bus.W_mst_id_o, g);
      check("w_awlen", bus.W_AWLEN_o, pend_ln[g]);
      expq.push_back(e);
      pend_v[g] = 1'b0;
      ptr = g;
    end else begin
      check("aw_axid_idle", bus.AW_AxID_o, 0);
      check("w_mst_id_idle", bus.W_mst_id_o, 0);
      check("w_awlen_idle", bus.W_AWLEN_o, 0);
    end
    model_held = (g >= 0) || (model_held && !bus.m_AWREADY_i);
  endtask

  task automatic step(input int p_req, input int p_rdy, input int p_aws, input int p_ws);
    @(posedge clk);
    #1;
    for (int m = 0; m < NM; m++)
      if (!pend_v[m] && int'($urandom_range(99)) < p_req) new_req(m);
    drive_bus();
    bus.m_AWREADY_i = int'($urandom_range(99)) < p_rdy;
    bus.AW_stall_i  = int'($urandom_range(99)) < p_aws;
    bus.W_stall_i   = int'($urandom_range(99)) < p_ws;
    @(negedge clk);
    model_check();
  endtask

  // Output monitor: compares the held register against the queue head while valid.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.m_AWVALID_o === 1'b1) begin
        if (expq.size() == 0) begin
          check("m_unexpected", 1, 0);
        end else begin
          check("m_awid", bus.m_AWID_o, expq[0].id);
          check("m_awaddr", bus.m_AWADDR_o, expq[0].addr);
          check("m_awlen", bus.m_AWLEN_o, expq[0].len);
          check("m_awsize", bus.m_AWSIZE_o, expq[0].size);
          if (bus.m_AWREADY_i) void'(expq.pop_front());
        end
      end
    end
  end

  initial begin
    for (int m = 0; m < NM; m++) begin
      pend_v[m] = 1'b0; pend_id[m] = '0; pend_ad[m] = '0;
      pend_ln[m] = '0; pend_sz[m] = '0; pend_x[m] = 1'b0;
    end
    drive_bus();
    bus.dsp_AWVALID_i = '1;
    bus.m_AWREADY_i = 1'b1;
    bus.AW_stall_i  = 1'b0;
    bus.W_stall_i   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_awvalid", bus.m_AWVALID_o, 0);
    check("rst_awid", bus.m_AWID_o, 0);
    check("rst_awaddr", bus.m_AWADDR_o, 0);
    check("rst_awready", bus.dsp_AWREADY_o, 0);
    check("rst_shift", bus.AW_shift_en_o, 0);
    check("rst_push", bus.W_push_o, 0);
    bus.dsp_AWVALID_i = '0;
    rst = 1'b0;

    // Master 1: AWID=5, ADDR=0x100, LEN=3.
    pend_v[1] = 1'b1; pend_id[1] = 5'd5; pend_ad[1] = 32'h100;
    pend_ln[1] = 8'd3; pend_sz[1] = 3'd2; pend_x[1] = 1'b0;
    step(0, 100, 0, 0);
    check("tp1_awready", bus.dsp_AWREADY_o, 3'b010);
    check("tp1_axid", bus.AW_AxID_o, 7'b01_00101);
    check("tp1_wmst", bus.W_mst_id_o, 1);
    step(0, 100, 0, 0);
    check("tp1_mvalid", bus.m_AWVALID_o, 1);
    check("tp1_mid", bus.m_AWID_o, 7'h25);
    repeat (2) step(0, 100, 0, 0);

    // Continuous requests from all masters.
    repeat (12) step(100, 100, 0, 0);
    repeat (3) step(0, 100, 0, 0);

    // Back-pressure from the slave with master 0 waiting.
    for (int i = 0; i < 6; i++) begin
      if (!pend_v[0]) new_req(0);
      step(0, (i < 5) ? 0 : 100, 0, 0);
    end
    repeat (3) step(0, 100, 0, 0);

    // Response-filter stall, then release.
    repeat (3) step(100, 100, 100, 0);
    repeat (3) step(100, 100, 0, 0);

    // W-ordering stall while a transaction drains.
    repeat (2) step(0, 100, 0, 100);
    repeat (3) step(0, 100, 0, 0);

    // Crossing flag from master 2.
    new_req(2);
    pend_x[2] = 1'b1;
    step(0, 100, 0, 0);
    check("tp_cross", bus.AW_crossing_flag_o, 1);
    check("tp_cross_shift", bus.AW_shift_en_o, 1);

    repeat (400) step(50, 60, 15, 15);

    // Reset while a transaction is held.
    for (int m = 0; m < NM; m++) pend_v[m] = 1'b0;
    repeat (3) step(0, 100, 0, 0);
    new_req(0);
    step(0, 0, 0, 0);
    new_req(0);
    @(posedge clk);
    #1;
    drive_bus();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_mvalid", bus.m_AWVALID_o, 0);
    check("midrst_mid", bus.m_AWID_o, 0);
    check("midrst_awready", bus.dsp_AWREADY_o, 0);
    check("midrst_shift", bus.AW_shift_en_o, 0);
    for (int m = 0; m < NM; m++) pend_v[m] = 1'b0;
    drive_bus();
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    model_held = 1'b0;
    ptr = NM - 1;

    repeat (150) step(60, 70, 10, 10);
    for (int m = 0; m < NM; m++) pend_v[m] = 1'b0;
    repeat (4) step(0, 100, 0, 0);
    check("drain_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sa_aw_channel.md
Name: sa_AW_channel

Overview:
Write-address stage of the slave arbiter. It round-robin arbitrates AW requests from MST_AMT dispatchers and prepends the granted master index to AWID. Each accepted transaction goes into a one-entry output register toward the slave. In the same cycle it notifies the write-response stage (ID and crossing flag) and the write-data stage (master index and AWLEN) so they can order their traffic.

Parameters:
MST_AMT, 3, number of masters/dispatchers
MST_ID_W, $clog2(MST_AMT), master index width
TRANS_MST_ID_W, 5, master-side AWID width
TRANS_SLV_ID_W, TRANS_MST_ID_W+MST_ID_W, slave-side AWID width
ADDR_WIDTH, 32, AWADDR width
TRANS_DATA_LEN_W, 8, AWLEN width
TRANS_DATA_SIZE_W, 3, AWSIZE width

Ports:
ACLK_i  in  1  clock
ARESET_i  in  1  asynchronous active-high reset
dsp_AWID_i  in  TRANS_MST_ID_W*MST_AMT  per-master AWID, master m at slice m
dsp_AWADDR_i  in  ADDR_WIDTH*MST_AMT  per-master AWADDR
dsp_AWLEN_i  in  TRANS_DATA_LEN_W*MST_AMT  per-master AWLEN
dsp_AWSIZE_i  in  TRANS_DATA_SIZE_W*MST_AMT  per-master AWSIZE
dsp_AW_crossing_flag_i  in  MST_AMT  transaction is one half of a split (boundary-crossing) burst
dsp_AWVALID_i  in  MST_AMT  request valid
dsp_AWREADY_o  out  MST_AMT  grant/accept, one-hot or zero
m_AWID_o  out  TRANS_SLV_ID_W  {master index, AWID}
m_AWADDR_o  out  ADDR_WIDTH  registered address
m_AWLEN_o  out  TRANS_DATA_LEN_W  registered length
m_AWSIZE_o  out  TRANS_DATA_SIZE_W  registered size
m_AWVALID_o  out  1  output register holds a transaction
m_AWREADY_i  in  1  slave accepts
AW_AxID_o  out  TRANS_SLV_ID_W  ID pushed to response filter
AW_crossing_flag_o  out  1  crossing flag pushed to response filter
AW_shift_en_o  out  1  push strobe to response filter
AW_stall_i  in  1  response filter FIFO full
W_mst_id_o  out  MST_ID_W  master index pushed to W ordering FIFO
W_AWLEN_o  out  TRANS_DATA_LEN_W  burst length pushed to W ordering FIFO
W_push_o  out  1  push strobe to W ordering FIFO
W_stall_i  in  1  W ordering FIFO full

Behaviour:
- Reset (async, ARESET_i=1): m_AWVALID_o=0, all m_* data=0, last_grant=MST_AMT-1 (master 0 has first priority). dsp_AWREADY_o, AW_shift_en_o and W_push_o are 0 while reset is held. Reset mid-transfer drops the held transaction immediately; no recovery.
- Two states from m_AWVALID_o: EMPTY (0) and HELD (1).
- Slot free this cycle: slot_free = ~m_AWVALID_o | m_AWREADY_i.
- Arbitrate enable: arb_en = slot_free & ~AW_stall_i & ~W_stall_i & |dsp_AWVALID_i.
- Round-robin: search masters starting at last_grant+1 (mod MST_AMT). The first valid master g wins.
- On grant, all combinational in the same cycle:
  - dsp_AWREADY_o[g]=1.
  - AW_shift_en_o=1, AW_AxID_o={g, dsp_AWID_i[g]}, AW_crossing_flag_o=dsp_AW_crossing_flag_i[g].
  - W_push_o=1, W_mst_id_o=g, W_AWLEN_o=dsp_AWLEN_i[g].
- Next edge after a grant: the output register loads g's fields, m_AWVALID_o=1, last_grant=g.
- Latency: request to m_AWVALID_o is 1 cycle.
- AW_shift_en_o and W_push_o are each asserted exactly once per accepted request, and only together with a dsp_AWREADY_o bit.
- Drain without a new grant: HELD→EMPTY.
- Simultaneous drain and grant: register reloads and m_AWVALID_o stays 1, giving one transaction per cycle.
- HELD with ~m_AWREADY_i: register contents are stable (AXI hold rule) and no grant is issued.
- Either stall input high: no grant; the held transaction can still drain; last_grant is unchanged.
- Non-granted requesters keep waiting; a master's dsp_AWREADY_o never asserts while its AWVALID is low.
- AW_AxID_o, W_mst_id_o and W_AWLEN_o are don't-care when their strobe is low; they are driven as 0.

Optional Feature:
- Macro SA_AW_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest index wins; last_grant register is removed.
- Undefined: round-robin as above.

Test Plan:
- Reset, then master 1 sends AWID=5, ADDR=0x100, LEN=3 → same cycle: dsp_AWREADY_o=3'b010, AW_AxID_o=7'b01_00101, W_push_o=1, W_mst_id_o=1. Next cycle: m_AWVALID_o=1, m_AWID_o=0x25.
- All 3 masters valid continuously, m_AWREADY_i=1 → grant order 0,1,2,0,1,2 at one grant per cycle; m_AWVALID_o held high.
- m_AWREADY_i=0 for 4 cycles with master 0 valid → one grant only; m_AW* stable 4 cycles; second grant in the cycle m_AWREADY_i returns to 1.
- AW_stall_i=1 with masters valid → dsp_AWREADY_o=0, no shift/push. Release → grant resumes at the saved priority pointer.
- W_stall_i=1 while HELD drains → m_AWVALID_o falls to 0 and no new grant.
- Master 2 with crossing flag=1 → AW_crossing_flag_o=1 pulsed with AW_shift_en_o. Assert ARESET_i mid-HELD → m_AWVALID_o=0 immediately.
